mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/wait_counter.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-side bus controller and its wait counter.
package mem_bus_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        ACTIVE
    } state_t;

    typedef enum logic {
        SEL_ROM,
        SEL_RAM
    } sel_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter; tc flags the last wait cycle (count == 1) so the owner
// can leave its wait state on the following edge.
module wait_counter
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// T80 memory-cycle decoder: registered ROM/RAM strobes, programmable wait states,
// sticky bus-error flag and a wrapping completed-read counter.
//
// state   | meaning
// IDLE    | no access; all strobes and WAIT_n high
// WAITING | strobes low, WAIT_n low while the wait counter runs
// ACTIVE  | strobes held, WAIT_n high until MREQ_n is sampled high
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0
) (
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic        MREQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        RFSH_n,
    output logic        WAIT_n,
    output logic        ROM_CE_n,
    output logic        ROM_OE_n,
    output logic [14:0] ROM_A,
    output logic        RAM_CE_n,
    output logic        RAM_OE_n,
    output logic        RAM_WE_n,
    output logic [14:0] RAM_A,
    output logic        BUS_ERR,
    output logic [15:0] RD_CNT
);

    localparam logic [CNT_W-1:0] ROM_WAIT_V = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_WAIT_V = CNT_W'(RAM_WAIT);

    state_t           state;
    sel_t             req_sel;
    logic             req;
    logic             conflict;
    logic [CNT_W-1:0] req_wait;
    logic             is_rd;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_tc;

    always_comb begin
        req      = !MREQ_n && RFSH_n && (RD_n ^ WR_n);
        conflict = !MREQ_n && RFSH_n && !RD_n && !WR_n;
        req_sel  = A[15] ? SEL_RAM : SEL_ROM;
        req_wait = (req_sel == SEL_RAM) ? RAM_WAIT_V : ROM_WAIT_V;
        cnt_load = (state == IDLE) && req && (req_wait != '0);
        cnt_en   = (state == WAITING);
    end

    wait_counter u_wait_counter (
        .clk      (CLK_n),
        .rst      (RESET),
        .load     (cnt_load),
        .load_val (req_wait),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            state    <= IDLE;
            is_rd    <= 1'b0;
            WAIT_n   <= 1'b1;
            ROM_CE_n <= 1'b1;
            ROM_OE_n <= 1'b1;
            RAM_CE_n <= 1'b1;
            RAM_OE_n <= 1'b1;
            RAM_WE_n <= 1'b1;
            ROM_A    <= '0;
            RAM_A    <= '0;
            BUS_ERR  <= 1'b0;
            RD_CNT   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (conflict) begin
                        BUS_ERR <= 1'b1;
                    end else if (req) begin
                        is_rd <= !RD_n;
                        if (req_sel == SEL_ROM) ROM_A <= A[14:0];
                        else                    RAM_A <= A[14:0];
                        // A ROM write still runs its wait states so CPU timing is unchanged.
                        if (req_sel == SEL_ROM && !WR_n) BUS_ERR <= 1'b1;
                        ROM_CE_n <= !(req_sel == SEL_ROM && !RD_n);
                        ROM_OE_n <= !(req_sel == SEL_ROM && !RD_n);
                        RAM_CE_n <= !(req_sel == SEL_RAM);
                        RAM_OE_n <= !(req_sel == SEL_RAM && !RD_n);
                        RAM_WE_n <= !(req_sel == SEL_RAM && !WR_n);
                        if (req_wait != '0) begin
                            state  <= WAITING;
                            WAIT_n <= 1'b0;
                        end else begin
                            state  <= ACTIVE;
                        end
                    end
                end
                WAITING: begin
                    if (MREQ_n) begin
                        state    <= IDLE;
                        WAIT_n   <= 1'b1;
                        ROM_CE_n <= 1'b1;
                        ROM_OE_n <= 1'b1;
                        RAM_CE_n <= 1'b1;
                        RAM_OE_n <= 1'b1;
                        RAM_WE_n <= 1'b1;
                    end else if (cnt_tc) begin
                        state  <= ACTIVE;
                        WAIT_n <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (MREQ_n) begin
                        state    <= IDLE;
                        ROM_CE_n <= 1'b1;
                        ROM_OE_n <= 1'b1;
                        RAM_CE_n <= 1'b1;
                        RAM_OE_n <= 1'b1;
                        RAM_WE_n <= 1'b1;
                        if (is_rd) RD_CNT <= RD_CNT + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (ROM/RAM waits 1/0 and 3/2) share the CPU bus
// and are checked against a cycle-timeline reference model.
module tb_mem_bus_ctrl;

    logic        CLK_n = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic        MREQ_n, RD_n, WR_n, RFSH_n;

    logic        wait_n [2];
    logic        rom_ce_n [2];
    logic        rom_oe_n [2];
    logic        ram_ce_n [2];
    logic        ram_oe_n [2];
    logic        ram_we_n [2];
    logic        bus_err [2];
    logic [14:0] rom_a_o [2];
    logic [14:0] ram_a_o [2];
    logic [15:0] cnt_o [2];
    logic [6:0]  obs [2];

    logic [6:0]  log_v [2][16];
    logic [14:0] log_rom_a [2];
    logic [14:0] log_ram_a [2];

    logic        exp_err [2];
    logic [15:0] exp_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK_n = ~CLK_n;

    mem_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0)) u_dut0 (
        .CLK_n(CLK_n), .RESET(RESET), .A(A), .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .RFSH_n(RFSH_n), .WAIT_n(wait_n[0]), .ROM_CE_n(rom_ce_n[0]), .ROM_OE_n(rom_oe_n[0]),
        .ROM_A(rom_a_o[0]), .RAM_CE_n(ram_ce_n[0]), .RAM_OE_n(ram_oe_n[0]),
        .RAM_WE_n(ram_we_n[0]), .RAM_A(ram_a_o[0]), .BUS_ERR(bus_err[0]), .RD_CNT(cnt_o[0])
    );

    mem_bus_ctrl #(.ROM_WAIT(3), .RAM_WAIT(2)) u_dut1 (
        .CLK_n(CLK_n), .RESET(RESET), .A(A), .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .RFSH_n(RFSH_n), .WAIT_n(wait_n[1]), .ROM_CE_n(rom_ce_n[1]), .ROM_OE_n(rom_oe_n[1]),
        .ROM_A(rom_a_o[1]), .RAM_CE_n(ram_ce_n[1]), .RAM_OE_n(ram_oe_n[1]),
        .RAM_WE_n(ram_we_n[1]), .RAM_A(ram_a_o[1]), .BUS_ERR(bus_err[1]), .RD_CNT(cnt_o[1])
    );

    // {ROM_CE_n, ROM_OE_n, RAM_CE_n, RAM_OE_n, RAM_WE_n, WAIT_n, BUS_ERR}
    assign obs[0] = {rom_ce_n[0], rom_oe_n[0], ram_ce_n[0], ram_oe_n[0], ram_we_n[0], wait_n[0], bus_err[0]};
    assign obs[1] = {rom_ce_n[1], rom_oe_n[1], ram_ce_n[1], ram_oe_n[1], ram_we_n[1], wait_n[1], bus_err[1]};

    function automatic int wait_of(int d, logic [15:0] a);
        if (a[15]) return (d == 0) ? 0 : 2;
        return (d == 0) ? 1 : 3;
    endfunction

    // Output vector k cycles after the request edge, MREQ_n held low for len sampled edges.
    function automatic logic [6:0] exp_vec(int n, logic [15:0] a, logic rd_n, logic wr_n,
                                           logic rfsh_n, int k, int len, logic err_in);
        logic req, rom, wr, act, wlo, err;
        req = rfsh_n && (rd_n != wr_n);
        rom = !a[15];
        wr  = !wr_n;
        act = req && (k < len);
        wlo = act && (k < n);
        err = err_in || (rfsh_n && !rd_n && !wr_n) || (req && rom && wr);
        return {!(act && rom && !wr), !(act && rom && !wr), !(act && !rom),
                !(act && !rom && !wr), !(act && !rom && wr), !wlo, err};
    endfunction

    task automatic model_step(input logic [15:0] a, input logic rd_n, input logic wr_n,
                              input logic rfsh_n, input int len);
        logic req;
        req = rfsh_n && (rd_n != wr_n);
        for (int d = 0; d < 2; d++) begin
            if ((rfsh_n && !rd_n && !wr_n) || (req && !a[15] && !wr_n)) exp_err[d] = 1'b1;
            if (req && !rd_n && len > wait_of(d, a)) exp_cnt[d] = exp_cnt[d] + 16'd1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_err[d] = 1'b0;
            exp_cnt[d] = 16'd0;
        end
    endtask

    task automatic idle_bus();
        MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; RFSH_n = 1'b1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        @(negedge CLK_n);
        RESET = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; leaves the bus idle at a negedge after the release edge.
    task automatic drive_access(input logic [15:0] a, input logic rd_n, input logic wr_n,
                                input logic rfsh_n, input int len);
        A = a; RD_n = rd_n; WR_n = wr_n; RFSH_n = rfsh_n; MREQ_n = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(negedge CLK_n);
            for (int d = 0; d < 2; d++) begin
                log_v[d][k] = obs[d];
                if (k == 0) begin
                    log_rom_a[d] = rom_a_o[d];
                    log_ram_a[d] = ram_a_o[d];
                end
            end
            if (k == len - 1) idle_bus();
        end
    endtask

    task automatic test_reset();
        idle_bus();
        A = 16'h0000;
        RESET = 1'b1;
        repeat (3) @(negedge CLK_n);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 7'b1111110 || cnt_o[d] !== 16'd0 || rom_a_o[d] !== 15'd0 || ram_a_o[d] !== 15'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: outputs=%b cnt=%h rom_a=%h ram_a=%h, required 1111110/0/0/0",
                         d, obs[d], cnt_o[d], rom_a_o[d], ram_a_o[d]);
            end
        end
        RESET = 1'b0;
        model_reset();
        @(negedge CLK_n);
    endtask

    task automatic test_rom_read();
        logic [6:0] exp_t [4];
        exp_t = '{7'b0011100, 7'b0011110, 7'b0011110, 7'b1111110};
        drive_access(16'h0003, 1'b0, 1'b1, 1'b1, 3);
        model_step(16'h0003, 1'b0, 1'b1, 1'b1, 3);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (log_v[0][k] !== exp_t[k]) begin
                n_fail++;
                $display("FAIL rom_read k=%0d: outputs=%b required %b", k, log_v[0][k], exp_t[k]);
            end
        end
        n_checks++;
        if (log_rom_a[0] !== 15'h0003 || cnt_o[0] !== 16'd1 || cnt_o[1] !== exp_cnt[1]) begin
            n_fail++;
            $display("FAIL rom_read addr/count: rom_a=%h cnt0=%h cnt1=%h required 0003/0001/%h",
                     log_rom_a[0], cnt_o[0], cnt_o[1], exp_cnt[1]);
        end
    endtask

    task automatic test_ram_write();
        logic [6:0] exp_t [3];
        exp_t = '{7'b1101010, 7'b1101010, 7'b1111110};
        drive_access(16'h8010, 1'b1, 1'b0, 1'b1, 2);
        model_step(16'h8010, 1'b1, 1'b0, 1'b1, 2);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (log_v[0][k] !== exp_t[k]) begin
                n_fail++;
                $display("FAIL ram_write k=%0d: outputs=%b required %b", k, log_v[0][k], exp_t[k]);
            end
        end
        n_checks++;
        if (log_ram_a[0] !== 15'h0010 || cnt_o[0] !== exp_cnt[0]) begin
            n_fail++;
            $display("FAIL ram_write addr/count: ram_a=%h cnt=%h required 0010/%h",
                     log_ram_a[0], cnt_o[0], exp_cnt[0]);
        end
    endtask

    task automatic test_abort();
        drive_access(16'h0005, 1'b0, 1'b1, 1'b1, 1);
        model_step(16'h0005, 1'b0, 1'b1, 1'b1, 1);
        n_checks++;
        if (log_v[1][0] !== 7'b0011100 || log_v[1][1] !== 7'b1111110) begin
            n_fail++;
            $display("FAIL abort strobes: k0=%b k1=%b required 0011100/1111110", log_v[1][0], log_v[1][1]);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (cnt_o[d] !== exp_cnt[d]) begin
                n_fail++;
                $display("FAIL abort count dut%0d: cnt=%h required %h", d, cnt_o[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_refresh();
        drive_access(16'h0042, 1'b0, 1'b1, 1'b0, 2);
        model_step(16'h0042, 1'b0, 1'b1, 1'b0, 2);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (log_v[d][k] !== {6'b111111, exp_err[d]}) begin
                    n_fail++;
                    $display("FAIL refresh dut%0d k=%0d: outputs=%b required %b",
                             d, k, log_v[d][k], {6'b111111, exp_err[d]});
                end
            end
            n_checks++;
            if (cnt_o[d] !== exp_cnt[d]) begin
                n_fail++;
                $display("FAIL refresh count dut%0d: cnt=%h required %h", d, cnt_o[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_rom_write_err();
        logic [6:0] exp_t [4];
        exp_t = '{7'b1111101, 7'b1111111, 7'b1111111, 7'b1111111};
        drive_access(16'h0100, 1'b1, 1'b0, 1'b1, 3);
        model_step(16'h0100, 1'b1, 1'b0, 1'b1, 3);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (log_v[0][k] !== exp_t[k]) begin
                n_fail++;
                $display("FAIL rom_write k=%0d: outputs=%b required %b", k, log_v[0][k], exp_t[k]);
            end
        end
        drive_access(16'h8020, 1'b0, 1'b1, 1'b1, 4);
        model_step(16'h8020, 1'b0, 1'b1, 1'b1, 4);
        n_checks++;
        if (bus_err[0] !== 1'b1 || bus_err[1] !== 1'b1 || cnt_o[0] !== exp_cnt[0]) begin
            n_fail++;
            $display("FAIL err_sticky: bus_err=%b%b cnt=%h required 11/%h",
                     bus_err[0], bus_err[1], cnt_o[0], exp_cnt[0]);
        end
        pulse_reset();
        n_checks++;
        if (bus_err[0] !== 1'b0 || bus_err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: bus_err=%b%b required 00", bus_err[0], bus_err[1]);
        end
    endtask

    task automatic test_conflict();
        drive_access(16'h8000, 1'b0, 1'b0, 1'b1, 2);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (log_v[d][k] !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL conflict dut%0d k=%0d: outputs=%b required 1111111", d, k, log_v[d][k]);
                end
            end
        end
        pulse_reset();
    endtask

    task automatic test_wrap_and_reset();
        force u_dut0.RD_CNT = 16'hFFFF;
        @(negedge CLK_n);
        release u_dut0.RD_CNT;
        exp_cnt[0] = 16'hFFFF;
        drive_access(16'h8000, 1'b0, 1'b1, 1'b1, 2);
        model_step(16'h8000, 1'b0, 1'b1, 1'b1, 2);
        n_checks++;
        if (cnt_o[0] !== 16'h0000 || exp_cnt[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap: cnt=%h required 0000", cnt_o[0]);
        end
        force u_dut0.RD_CNT = 16'hFFFF;
        @(negedge CLK_n);
        release u_dut0.RD_CNT;
        A = 16'h8004; RD_n = 1'b0; MREQ_n = 1'b0;
        @(negedge CLK_n);
        n_checks++;
        if (obs[0] !== 7'b1100110) begin
            n_fail++;
            $display("FAIL active_before_reset: outputs=%b required 1100110", obs[0]);
        end
        RESET = 1'b1;
        @(negedge CLK_n);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs[d] !== 7'b1111110 || cnt_o[d] !== 16'd0 || rom_a_o[d] !== 15'd0 || ram_a_o[d] !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_in_active dut%0d: outputs=%b cnt=%h rom_a=%h ram_a=%h required 1111110/0/0/0",
                         d, obs[d], cnt_o[d], rom_a_o[d], ram_a_o[d]);
            end
        end
        RESET = 1'b0;
        idle_bus();
        model_reset();
        @(negedge CLK_n);
        n_checks++;
        if (cnt_o[0] !== 16'd0 || obs[0] !== 7'b1111110) begin
            n_fail++;
            $display("FAIL after_reset: cnt=%h outputs=%b required 0000/1111110", cnt_o[0], obs[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        rd_n, wr_n, rfsh_n;
        logic [6:0]  e;
        int          kind, len;
        pulse_reset();
        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 19) pulse_reset();
            a      = 16'($urandom);
            kind   = $urandom_range(0, 9);
            len    = $urandom_range(1, 6);
            rfsh_n = 1'b1;
            if (kind == 0) begin
                rfsh_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
            end else if (kind == 1) begin
                rd_n = 1'b0; wr_n = 1'b0;
            end else begin
                wr_n = 1'($urandom_range(0, 1));
                rd_n = !wr_n;
            end
            drive_access(a, rd_n, wr_n, rfsh_n, len);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k <= len; k++) begin
                    e = exp_vec(wait_of(d, a), a, rd_n, wr_n, rfsh_n, k, len, exp_err[d]);
                    n_checks++;
                    if (log_v[d][k] !== e) begin
                        n_fail++;
                        $display("FAIL random i=%0d dut%0d k=%0d a=%h rd_n=%b wr_n=%b rfsh_n=%b len=%0d: outputs=%b required %b",
                                 i, d, k, a, rd_n, wr_n, rfsh_n, len, log_v[d][k], e);
                    end
                end
                if (rfsh_n && (rd_n != wr_n)) begin
                    n_checks++;
                    if ((!a[15] && log_rom_a[d] !== a[14:0]) || (a[15] && log_ram_a[d] !== a[14:0])) begin
                        n_fail++;
                        $display("FAIL random_addr i=%0d dut%0d: rom_a=%h ram_a=%h required %h",
                                 i, d, log_rom_a[d], log_ram_a[d], a[14:0]);
                    end
                end
            end
            model_step(a, rd_n, wr_n, rfsh_n, len);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (cnt_o[d] !== exp_cnt[d]) begin
                    n_fail++;
                    $display("FAIL random_count i=%0d dut%0d: cnt=%h required %h", i, d, cnt_o[d], exp_cnt[d]);
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        A = 16'h0000;
        idle_bus();
        model_reset();
        @(negedge CLK_n);
        test_reset();
        test_rom_read();
        test_ram_write();
        test_abort();
        test_refresh();
        test_rom_write_err();
        test_conflict();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
